// File: rtl/anim_sequencer.sv
// Multi-channel animation frame sequencer.
// A single free-running tick counter produces the shared frame-advance strobe.
// Each channel steps its frame number on that strobe in one-shot, loop or
// ping-pong fashion. Mode and last frame are captured when the channel starts.
module anim_sequencer #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int FRAME_RATE = 60,
    parameter int NUM_CH     = 4,
    parameter int FRAME_W    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           start,
    input  logic [NUM_CH-1:0]           stop,
    input  logic [2*NUM_CH-1:0]         mode,
    input  logic [FRAME_W*NUM_CH-1:0]   last_frame,
    output logic [FRAME_W*NUM_CH-1:0]   frame_num,
    output logic [NUM_CH-1:0]           busy,
    output logic [NUM_CH-1:0]           done,
    output logic                        frame_tick
);

    localparam int CPF   = CLOCK_FREQ / FRAME_RATE;
    localparam int CNT_W = (CPF > 1) ? $clog2(CPF) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(CPF - 1);
    localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        REV  = 2'd2
    } ch_state_t;

    logic [CNT_W-1:0] tick_cnt_reg;

    // Free-running tick counter; never disturbed by channel activity so all
    // channels advance on the same globally aligned strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_reg <= '0;
        end else if (tick_cnt_reg == CNT_MAX) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
    end

    // With CPF==1 the counter sits at 0 == CNT_MAX, so the strobe is constant.
    assign frame_tick = (tick_cnt_reg == CNT_MAX);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        ch_state_t          state_reg;
        logic [1:0]         mode_reg;
        logic [FRAME_W-1:0] last_reg;
        logic [FRAME_W-1:0] frame_reg;
        logic               done_reg;

        // Channel FSM: start (re)arms and wins over stop; stop freezes the
        // frame; otherwise the frame steps on the shared strobe.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_reg <= IDLE;
                mode_reg  <= '0;
                last_reg  <= '0;
                frame_reg <= '0;
                done_reg  <= 1'b0;
            end else if (start[gi]) begin
                mode_reg  <= mode[2*gi +: 2];
                last_reg  <= last_frame[FRAME_W*gi +: FRAME_W];
                frame_reg <= '0;
                state_reg <= FWD;
                done_reg  <= 1'b0;
            end else if (stop[gi]) begin
                state_reg <= IDLE;
                done_reg  <= 1'b0;
            end else begin
                done_reg <= 1'b0;
                if (frame_tick) begin
                    case (state_reg)
                        FWD: begin
                            if (frame_reg < last_reg) begin
                                frame_reg <= frame_reg + FRAME_ONE;
                            end else if (mode_reg == 2'b01) begin
                                // Loop: wrap back to the first frame.
                                frame_reg <= '0;
                                done_reg  <= 1'b1;
                            end else if (mode_reg == 2'b10) begin
                                // Ping-pong: turn around, unless a single-frame
                                // sequence, which just reports each period.
                                if (last_reg != '0) begin
                                    state_reg <= REV;
                                    frame_reg <= last_reg - FRAME_ONE;
                                end else begin
                                    done_reg <= 1'b1;
                                end
                            end else begin
                                // One-shot (mode 00 or 11): park on last frame.
                                state_reg <= IDLE;
                                done_reg  <= 1'b1;
                            end
                        end
                        REV: begin
                            if (frame_reg != '0) begin
                                frame_reg <= frame_reg - FRAME_ONE;
                            end else begin
                                state_reg <= FWD;
                                frame_reg <= (last_reg == '0) ? '0 : FRAME_ONE;
                                done_reg  <= 1'b1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end

        assign frame_num[FRAME_W*gi +: FRAME_W] = frame_reg;
        assign busy[gi]                         = (state_reg != IDLE);
        assign done[gi]                         = done_reg;
    end

endmodule
